// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   state_t : loader FSM states
//   IMEM_*  : geometry of the instruction memory being written
//   LEN_MAX : largest frame length accepted, in words
package imem_loader_pkg;

   localparam int IMEM_DEPTH  = 64;
   localparam int IMEM_ADDR_W = 6;
   localparam int IMEM_DATA_W = 32;
   localparam int LEN_MAX     = 64;

   typedef enum logic [2:0] {
      WAIT_LEN,
      DATA,
      CHECK,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the loader's byte-stream input, control and memory write port.
//   slave  : loader side (consumes rx bytes/start, drives write port and status)
//   master : driver side (UART receiver / control logic / bench)
interface imem_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              start;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              cpu_hold;
   logic              done;
   logic              error;

   modport slave (
      input  rx_valid, rx_data, start,
      output we, wa, wd, cpu_hold, done, error
   );

   modport master (
      output rx_valid, rx_data, start,
      input  we, wa, wd, cpu_hold, done, error
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler
//   Packs bytes MSB-first into 32-bit words and keeps a running XOR of
//   every byte accepted.
//   clk, rst       : clock, async active-high reset
//   i_clear        : synchronous clear of byte counter, shifter and checksum
//   i_valid/i_byte : byte strobe and value
//   o_word         : current word including the byte presented this cycle
//   o_word_ready   : high in the cycle the 4th byte of a word is presented
//   o_chk          : XOR of all bytes accepted since the last clear
module imem_loader_word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready,
   output logic [7:0]  o_chk
);
   // Only the three older bytes need storage; the 4th is taken straight
   // from the input so the word is ready in the same cycle it completes.
   logic [23:0] r_sr;
   logic [1:0]  r_cnt;
   logic [7:0]  r_chk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_chk <= '0;
      end else if (i_clear) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_chk <= '0;
      end else if (i_valid) begin
         r_sr  <= {r_sr[15:0], i_byte};
         r_cnt <= r_cnt + 2'd1;
         r_chk <= r_chk ^ i_byte;
      end
   end

   assign o_word       = {r_sr, i_byte};
   assign o_word_ready = i_valid && (r_cnt == 2'd3);
   assign o_chk        = r_chk;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a framed byte stream (LEN, LEN*4 data bytes, XOR checksum),
//   writes the assembled big-endian words into instruction memory and
//   holds the CPU in reset until a frame completes with a good checksum.
//   clk, reset : clock, async active-high reset
//   bus        : rx_valid/rx_data/start in; we/wa/wd write port and
//                cpu_hold/done/error status out
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.slave  bus
);
   state_t            r_state, w_state_nxt;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_widx;
   logic              r_we;
   logic [ADDR_W-1:0] r_wa;
   logic [DATA_W-1:0] r_wd;

   logic              w_clear;
   logic              w_asm_valid;
   logic              w_len_ok;
   logic [31:0]       w_word;
   logic              w_word_ready;
   logic [7:0]        w_chk;

   imem_loader_word_assembler u_asm (
      .clk          (clk),
      .rst          (reset),
      .i_clear      (w_clear),
      .i_valid      (w_asm_valid),
      .i_byte       (bus.rx_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready),
      .o_chk        (w_chk)
   );

   assign w_len_ok = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_asm_valid = 1'b0;
      case (r_state)
         WAIT_LEN: if (bus.rx_valid) w_state_nxt = w_len_ok ? DATA : ERROR;
         DATA: begin
            // Bytes reach the assembler only here, so writes can only
            // originate from DATA.
            w_asm_valid = bus.rx_valid;
            if (w_word_ready && (r_widx == r_len - 1'b1)) w_state_nxt = CHECK;
         end
         CHECK: if (bus.rx_valid) w_state_nxt = (bus.rx_data == w_chk) ? DONE : ERROR;
         DONE, ERROR: begin
            if (bus.start) begin
               w_state_nxt = WAIT_LEN;
               w_clear     = 1'b1;
            end
         end
         default: w_state_nxt = WAIT_LEN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= WAIT_LEN;
         r_len   <= '0;
         r_widx  <= '0;
         r_we    <= 1'b0;
         r_wa    <= '0;
         r_wd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_word_ready;
         if (r_state == WAIT_LEN && bus.rx_valid && w_len_ok)
            r_len <= bus.rx_data[ADDR_W:0];
         // wd is latched here rather than read from the shifter, so the
         // first byte of the next word may arrive during the write cycle.
         if (w_word_ready) begin
            r_wa   <= r_widx[ADDR_W-1:0];
            r_wd   <= DATA_W'(w_word);
            r_widx <= r_widx + 1'b1;
         end
         if (w_clear) begin
            r_wa   <= '0;
            r_widx <= '0;
         end
      end
   end

   assign bus.we       = r_we;
   assign bus.wa       = r_wa;
   assign bus.wd       = r_wd;
   assign bus.done     = (r_state == DONE);
   assign bus.error    = (r_state == ERROR);
   assign bus.cpu_hold = (r_state != DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the 64-word instruction memory. Receives a framed byte stream from the UART receiver, assembles big-endian 32-bit words and drives the memory's write port (we/wa/wd). Holds the CPU in reset until a load completes with a valid checksum. The instruction memory gains a synchronous write port driven by this block; its read port is unchanged.

Parameters:
ADDR_W, 6, word-address width of instruction memory
DEPTH, 64, number of words; maximum frame length
DATA_W, 32, instruction word width

Ports:
clk       in   1       system clock, rising edge
reset     in   1       asynchronous, active-high reset
rx_valid  in   1       one-cycle strobe: rx_data holds a received byte
rx_data   in   8       received byte
start     in   1       one-cycle re-arm pulse; honoured only in DONE/ERROR
we        out  1       instruction memory write enable, one cycle per word
wa        out  ADDR_W  instruction memory word address
wd        out  DATA_W  instruction memory write data
cpu_hold  out  1       1 = CPU held in reset
done      out  1       load finished, checksum good
error     out  1       frame rejected (bad length or checksum)

Behaviour:
- Frame: LEN byte (1..64 words), then LEN*4 data bytes (MSB first per word), then CHK byte = XOR of all data bytes (LEN excluded).
- Reset (async, any state): state=WAIT_LEN; we=0, wa=0, wd=0, done=0, error=0, cpu_hold=1; byte counter, word counter and checksum cleared. Words already written are not erased.
- WAIT_LEN: on rx_valid, if rx_data in 1..64, latch LEN and go to DATA. rx_data=0 or >64 goes to ERROR and no write occurs.
- DATA:
  - Each rx_valid shifts rx_data into a 32-bit shift register (left shift, new byte in bits 7:0), XORs it into the checksum and increments the 2-bit byte counter.
  - On the 4th byte of a word, on the next cycle: we=1 for exactly one cycle, wa=word index, wd=assembled word.
  - The word index increments after each write.
  - After write LEN-1 the state moves to CHECK.
- CHECK: on rx_valid, compare rx_data with the checksum.
  - Match: go to DONE; done=1, cpu_hold=0 from the next cycle.
  - Mismatch: go to ERROR; error=1, cpu_hold stays 1.
- DONE / ERROR: rx_valid is ignored.
  - A start pulse returns to WAIT_LEN. On the next cycle done=0, error=0, cpu_hold=1, wa=0, and checksum and counters are cleared.
  - start in any other state is ignored.
- Throughput: back-to-back rx_valid on every cycle is supported. A write cycle may coincide with the first byte of the next word, because wd is registered separately from the shift register.
- wa/wd hold their last values when we=0. we is never asserted outside DATA-derived write cycles. No more than LEN writes occur per frame, and wa never exceeds 63.
- cpu_hold is 0 only in DONE.

Decomposition:
- Shared package contents:
  - state enum: WAIT_LEN, DATA, CHECK, DONE, ERROR
  - constants IMEM_DEPTH=64, IMEM_ADDR_W=6, IMEM_DATA_W=32
  - LEN_MAX=64
- Sub-module word_assembler:
  - byte shift register, 2-bit byte counter, running XOR
  - outputs word, word_ready pulse, checksum
  - clear input
- The top level holds the FSM, word counter and write-port registers.

Test Plan:
- Single-word load: bytes 01, 28, 02, 00, 05, 2F on consecutive cycles. Expect one we pulse with wa=0, wd=0x28020005, then done=1, cpu_hold=0, error=0.
- Checksum mismatch: same frame with last byte 2E. Expect the write to wa=0 to occur, then error=1, done=0, cpu_hold=1.
- Bad length: LEN byte 00, then separately 41 after reset. Each goes to error=1 with no we pulse; following data bytes are ignored.
- Full 64-word back-to-back load of word i = 0x01000000+i with correct CHK. Expect 64 we pulses, wa 0..63 in order, wd matching, no gaps beyond one cycle per 4 bytes, then done=1.
- Reset mid-load after LEN=02 and 6 data bytes. Expect outputs at reset values. A subsequent 1-word frame writes wa=0 and reaches done.
- Re-arm: after done, pulse start. Expect done=0, cpu_hold=1, wa=0 next cycle. start pulsed during DATA has no effect.
